// File: rtl/tmds_decoder_if.sv
// TMDS decoder channel bus: one deserialized word in, decoded symbol and
// alignment status out. The optional lock-loss counter appears only when
// TMDS_DECODER_LOSSCNT_EN is defined.
interface tmds_decoder_if;
  logic [9:0] i_raw;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_display_enable;
  logic       o_locked;
  logic [3:0] o_offset;
`ifdef TMDS_DECODER_LOSSCNT_EN
  logic [15:0] o_lock_loss_cnt;
`endif

  // Deserializer side: supplies raw words, observes decoded results.
  modport master (
    output i_raw,
    input  o_data,
    input  o_ctrl,
    input  o_display_enable,
    input  o_locked,
`ifdef TMDS_DECODER_LOSSCNT_EN
    input  o_lock_loss_cnt,
`endif
    input  o_offset
  );

  // Decoder side.
  modport slave (
    input  i_raw,
    output o_data,
    output o_ctrl,
    output o_display_enable,
    output o_locked,
`ifdef TMDS_DECODER_LOSSCNT_EN
    output o_lock_loss_cnt,
`endif
    output o_offset
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS single-channel receive decoder (DVI mode).
// Finds the 10-bit symbol boundary by bit-slipping until a run of control
// tokens is seen, then decodes symbols into pixel byte / control / DE.
// Optional macro TMDS_DECODER_LOSSCNT_EN adds a saturating lock-loss counter.
module tmds_decoder #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WORDS = 2048,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic          i_hdmi_clk,
  input  logic          i_reset_n,
  tmds_decoder_if.slave bus
);

  localparam int MAX_WORDS = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
  localparam int CW        = $clog2(MAX_WORDS);
  localparam int RW        = $clog2(CTRL_RUN + 1);

  localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_WORDS - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_WORDS - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(CTRL_RUN - 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [9:0]    prev_reg;
  logic [18:0]   cat;
  logic [9:0]    cand [10];
  logic [9:0]    win;
  logic [9:0]    w_reg;
  logic          w_valid_reg, w_valid_next;
  logic [0:0]    state_reg, state_next;
  logic [3:0]    offset_reg, offset_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic [CW-1:0] gap_reg, gap_next;
  logic [RW-1:0] run_reg, run_next;
  logic          tok_hit, tok_ok;
  logic [1:0]    tok_ctrl;
  logic [7:0]    dec_d, dec_byte;
  logic [7:0]    data_reg, data_next;
  logic [1:0]    ctrl_reg, ctrl_next;
  logic          de_reg, de_next;

  // The top bit of the newest word can never fall inside a window (max
  // offset 9 reaches bit 18), so it only enters via prev_reg.
  assign cat = {bus.i_raw[8:0], prev_reg};

  // Every candidate alignment, one per bit-slip offset.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi] = cat[gi+9:gi];
    end
  endgenerate

  // Select the window for the current offset.
  always_comb begin
    win = cand[0];
    for (int i = 0; i < 10; i++) begin
      if (offset_reg == 4'(i)) win = cand[i];
    end
  end

  // Recognise the four DVI control tokens.
  always_comb begin
    tok_hit  = 1'b1;
    tok_ctrl = 2'b00;
    case (w_reg)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: tok_hit  = 1'b0;
    endcase
  end

  // A word captured across a slip is stale and must not count as a token.
  assign tok_ok = tok_hit & w_valid_reg;

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign dec_d       = w_reg[9] ? ~w_reg[7:0] : w_reg[7:0];
  assign dec_byte[0] = dec_d[0];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_byte[gi] = dec_d[gi] ^ dec_d[gi-1] ^ ~w_reg[8];
    end
  endgenerate

  // Alignment search / lock supervision.
  always_comb begin
    state_next   = state_reg;
    offset_next  = offset_reg;
    timer_next   = timer_reg;
    gap_next     = gap_reg;
    run_next     = run_reg;
    w_valid_next = 1'b1;
    case (state_reg)
      ST_SEARCH: begin
        if (tok_ok) begin
          // A token wins over an expiring timer: no slip this cycle.
          if (run_reg == RUN_LAST) begin
            state_next = ST_LOCKED;
            run_next   = '0;
            timer_next = '0;
            gap_next   = '0;
          end else begin
            run_next = run_reg + RW'(1);
            if (timer_reg != SEARCH_LAST) timer_next = timer_reg + CW'(1);
          end
        end else if (timer_reg == SEARCH_LAST) begin
          offset_next  = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
          timer_next   = '0;
          run_next     = '0;
          w_valid_next = 1'b0;
        end else begin
          timer_next = timer_reg + CW'(1);
          run_next   = '0;
        end
      end
      default: begin
        // A token on the expiry cycle keeps the lock.
        if (tok_ok) begin
          gap_next = '0;
        end else if (gap_reg == LOSS_LAST) begin
          state_next = ST_SEARCH;
          gap_next   = '0;
          run_next   = '0;
          timer_next = '0;
        end else begin
          gap_next = gap_reg + CW'(1);
        end
      end
    endcase
  end

  // Output stage follows the post-transition lock state so outputs and
  // o_locked change together.
  always_comb begin
    data_next = '0;
    ctrl_next = '0;
    de_next   = 1'b0;
    if (state_next == ST_LOCKED) begin
      if (tok_ok) begin
        ctrl_next = tok_ctrl;
      end else begin
        de_next   = 1'b1;
        data_next = dec_byte;
        ctrl_next = ctrl_reg;
      end
    end
  end

  // Alignment front end: previous word and stage-1 window.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_reg    <= '0;
      w_reg       <= '0;
      w_valid_reg <= 1'b0;
    end else begin
      prev_reg    <= bus.i_raw;
      w_reg       <= win;
      w_valid_reg <= w_valid_next;
    end
  end

  // FSM state, offset and counters.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= ST_SEARCH;
      offset_reg <= '0;
      timer_reg  <= '0;
      gap_reg    <= '0;
      run_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      timer_reg  <= timer_next;
      gap_reg    <= gap_next;
      run_reg    <= run_next;
    end
  end

  // Registered decoded outputs.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_reg <= '0;
      ctrl_reg <= '0;
      de_reg   <= 1'b0;
    end else begin
      data_reg <= data_next;
      ctrl_reg <= ctrl_next;
      de_reg   <= de_next;
    end
  end

  assign bus.o_data           = data_reg;
  assign bus.o_ctrl           = ctrl_reg;
  assign bus.o_display_enable = de_reg;
  assign bus.o_locked         = (state_reg == ST_LOCKED);
  assign bus.o_offset         = offset_reg;

`ifdef TMDS_DECODER_LOSSCNT_EN
  logic        lost;
  logic [15:0] loss_cnt_reg;

  assign lost = (state_reg == ST_LOCKED) && (state_next == ST_SEARCH);

  // Count lock drops, saturating; search slips never touch it.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      loss_cnt_reg <= '0;
    end else if (lost && (loss_cnt_reg != 16'hFFFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 16'd1;
    end
  end

  assign bus.o_lock_loss_cnt = loss_cnt_reg;
`endif

endmodule
